// File: rtl/mem_pkg.sv
// Shared types and default widths for the synchronous dual-port memory.
package mem_pkg;

  // Controller states: normal access, or sequential zeroing of the array.
  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Default word and address widths shared by the memory and its users.
  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 8;

endpackage

// File: rtl/sync_ram_core.sv
// Storage array with one write port and two registered read ports.
// The data read port is write-first, the instruction read port is read-first.
module sync_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_zero_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_zero_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [DATA_W-1:0] i_rdata_o
);

  // Index width covers exactly the array; callers gate out-of-range
  // addresses, so dropping the upper address bits never aliases a live access.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  d_idx;
  logic [IDX_W-1:0]  i_idx;
  logic              d_bypass;

  assign w_idx    = waddr_i[IDX_W-1:0];
  assign d_idx    = d_addr_i[IDX_W-1:0];
  assign i_idx    = i_addr_i[IDX_W-1:0];
  assign d_bypass = we_i && (waddr_i == d_addr_i);

  // Array write; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[w_idx] <= wdata_i;
    end
  end

  // Registered reads: data port forwards same-cycle write data, instruction
  // port sees the array contents from before this edge.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      if (d_zero_i)      d_rdata_q <= '0;
      else if (d_bypass) d_rdata_q <= wdata_i;
      else               d_rdata_q <= mem_q[d_idx];
      if (i_zero_i)      i_rdata_q <= '0;
      else               i_rdata_q <= mem_q[i_idx];
    end
  end

  assign d_rdata_o = d_rdata_q;
  assign i_rdata_o = i_rdata_q;

endmodule

// File: rtl/sync_dual_mem.sv
// Synchronous memory with a read/write data port, a read-only instruction
// port, range checking and a sequential clear engine.
module sync_dual_mem
  import mem_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH      = 2**ADDR_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] instruction,
  input  logic              clear_req,
  output logic              busy,
  output logic              addr_err
);

  // Counter is one bit wider than the address so DEPTH itself is representable.
  localparam logic [ADDR_W:0] LIM      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST     = (ADDR_W+1)'(DEPTH - 1);
  localparam state_t          RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              addr_err_q, addr_err_d;
  logic              d_in_range;
  logic              i_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              d_zero;
  logic              i_zero;

  assign d_in_range = {1'b0, address} < LIM;
  assign i_in_range = {1'b0, inst_address} < LIM;

  // State, clear counter and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Next state, clear sequencing, write gating and range checks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = address;
    ram_wdata  = data_in;
    d_zero     = 1'b0;
    i_zero     = 1'b0;
    case (state_q)
      ST_READY: begin
        d_zero = !d_in_range;
        i_zero = !i_in_range;
        if (clear_req) begin
          // Clear wins over a simultaneous write, which is dropped.
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          addr_err_d = !i_in_range;
        end else begin
          ram_we     = write_en && d_in_range;
          addr_err_d = (write_en && !d_in_range) || !i_in_range;
        end
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q[ADDR_W-1:0];
        ram_wdata = '0;
        d_zero    = 1'b1;
        i_zero    = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    endcase
  end

  sync_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk      (clk),
    .rst_ni   (reset_n),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .d_addr_i (address),
    .d_zero_i (d_zero),
    .i_addr_i (inst_address),
    .i_zero_i (i_zero),
    .d_rdata_o(data_out),
    .i_rdata_o(instruction)
  );

  assign busy     = (state_q == ST_CLEAR);
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_sync_dual_mem.sv
// Directed and randomized bench for sync_dual_mem against an array model.
module tb_sync_dual_mem;
  import mem_pkg::*;

  localparam int AW      = MEM_ADDR_W;
  localparam int DW      = MEM_DATA_W;
  localparam int DEPTH_A = 2**AW;
  localparam int DEPTH_B = 200;
  localparam int BOUND   = 1000;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] address, inst_address;
  logic [DW-1:0] data_in, data_out, instruction;
  logic          write_en, clear_req, busy, addr_err;

  logic [AW-1:0] b_address, b_inst_address;
  logic [DW-1:0] b_data_in, b_data_out, b_instruction;
  logic          b_write_en, b_clear_req, b_busy, b_addr_err;

  logic [DW-1:0] ma [DEPTH_A];
  logic [DW-1:0] mb [DEPTH_B];

  int n_checks = 0;
  int n_fail   = 0;
  int na, nb, ia, id;
  logic err_seen;
  logic [DW-1:0] wd, exp_d, exp_i;
  logic we;

  sync_dual_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A), .INIT_CLEAR(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .data_in(data_in),
    .write_en(write_en), .data_out(data_out), .inst_address(inst_address),
    .instruction(instruction), .clear_req(clear_req), .busy(busy), .addr_err(addr_err)
  );

  sync_dual_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .INIT_CLEAR(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_address), .data_in(b_data_in),
    .write_en(b_write_en), .data_out(b_data_out), .inst_address(b_inst_address),
    .instruction(b_instruction), .clear_req(b_clear_req), .busy(b_busy), .addr_err(b_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count how many sampled cycles each instance reports busy, bounded.
  task automatic count_busy(output int ca, output int cb, output logic seen_err);
    ca = 0;
    cb = 0;
    seen_err = 1'b0;
    while ((busy || b_busy) && (ca < BOUND) && (cb < BOUND)) begin
      if (busy) ca++;
      if (b_busy) cb++;
      seen_err = seen_err | addr_err | b_addr_err;
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0; inst_address = '0; data_in = '0; write_en = 1'b0; clear_req = 1'b0;
    b_address = '0; b_inst_address = '0; b_data_in = '0; b_write_en = 1'b0; b_clear_req = 1'b0;

    // Reset values
    repeat (2) step();
    chk("rst_busy", busy, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_inst", instruction, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_busy_b", b_busy, 1);

    // Initial clear duration
    reset_n = 1'b1;
    count_busy(na, nb, err_seen);
    chk("init_clear_len", na, DEPTH_A);
    chk("init_clear_len_b", nb, DEPTH_B);
    chk("init_clear_err", err_seen, 0);
    for (int i = 0; i < DEPTH_A; i++) ma[i] = '0;
    for (int i = 0; i < DEPTH_B; i++) mb[i] = '0;

    // Every word reads zero after the clear
    for (int i = 0; i < DEPTH_A; i++) begin
      address = AW'(i); inst_address = AW'(DEPTH_A - 1 - i);
      step();
      chk("zero_dout", data_out, ma[i]);
      chk("zero_inst", instruction, ma[DEPTH_A - 1 - i]);
      chk("zero_err", addr_err, 0);
    end

    // Writes 0..7 with instruction reads walking downward
    for (int i = 0; i < 8; i++) begin
      address = AW'(i); data_in = DW'(i); write_en = 1'b1; inst_address = AW'(7 - i);
      exp_i = ma[7 - i];
      step();
      ma[i] = DW'(i);
      chk("wr_dout", data_out, i);
      chk("wr_inst_old", instruction, exp_i);
    end
    write_en = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      inst_address = AW'(i);
      step();
      chk("inst_seq", instruction, i);
    end

    // Read-during-write: write-first data port, read-first instruction port
    address = 3; inst_address = 3; data_in = 8'hA5; write_en = 1'b1;
    step();
    ma[3] = 8'hA5;
    chk("rdw_dout", data_out, 8'hA5);
    chk("rdw_inst_old", instruction, 8'h03);
    write_en = 1'b0;
    step();
    chk("rdw_inst_new", instruction, 8'hA5);

    // Randomized traffic on the full-depth instance
    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom);
      ia = int'($urandom_range(DEPTH_A - 1, 0));
      id = int'($urandom_range(DEPTH_A - 1, 0));
      wd = DW'($urandom);
      address = AW'(ia); inst_address = AW'(id); data_in = wd; write_en = we;
      exp_d = we ? wd : ma[ia];
      exp_i = ma[id];
      step();
      if (we) ma[ia] = wd;
      chk("rnd_dout", data_out, exp_d);
      chk("rnd_inst", instruction, exp_i);
      chk("rnd_err", addr_err, 0);
    end
    write_en = 1'b0;

    // Fill with nonzero data so the later clear has something to erase
    for (int i = 0; i < DEPTH_A; i++) begin
      wd = DW'($urandom_range(255, 1));
      address = AW'(i); data_in = wd; write_en = 1'b1;
      step();
      ma[i] = wd;
    end
    write_en = 1'b0;

    // clear_req beats a simultaneous write; writes during busy are ignored
    address = 4; inst_address = 4; data_in = 8'h77; write_en = 1'b1; clear_req = 1'b1;
    exp_d = ma[4];
    step();
    chk("clr_busy_rise", busy, 1);
    chk("clr_dout_old", data_out, exp_d);
    chk("clr_inst_old", instruction, exp_d);
    na = 0;
    while (busy && na < BOUND) begin
      clear_req = 1'($urandom); write_en = 1'b1;
      address = AW'($urandom); data_in = DW'($urandom); inst_address = AW'($urandom);
      step();
      na++;
      chk("clr_dout_zero", data_out, 0);
      chk("clr_inst_zero", instruction, 0);
      chk("clr_err", addr_err, 0);
    end
    clear_req = 1'b0; write_en = 1'b0;
    chk("clr_len", na, DEPTH_A);
    for (int i = 0; i < DEPTH_A; i++) ma[i] = '0;
    address = 4; inst_address = 4;
    step();
    chk("clr_addr4", data_out, 0);
    for (int i = 0; i < DEPTH_A; i++) begin
      address = AW'(i); inst_address = AW'(i);
      step();
      chk("clr_scan", data_out, ma[i]);
    end

    // DEPTH=200 instance: fill, then out-of-range accesses
    for (int i = 0; i < DEPTH_B; i++) begin
      wd = DW'($urandom);
      b_address = AW'(i); b_data_in = wd; b_write_en = 1'b1;
      step();
      mb[i] = wd;
      chk("b_fill", b_data_out, wd);
    end
    b_address = 250; b_data_in = 8'h5A; b_write_en = 1'b1; b_inst_address = 0;
    step();
    chk("b_oor_wr_err", b_addr_err, 1);
    chk("b_oor_wr_dout", b_data_out, 0);
    b_write_en = 1'b0;
    step();
    chk("b_err_pulse", b_addr_err, 0);
    chk("b_oor_rd_dout", b_data_out, 0);
    b_inst_address = AW'(DEPTH_B - 1);
    step();
    chk("b_inst_last_err", b_addr_err, 0);
    chk("b_inst_last", b_instruction, mb[DEPTH_B - 1]);
    b_inst_address = AW'(DEPTH_B);
    step();
    chk("b_inst_oor_err", b_addr_err, 1);
    chk("b_inst_oor", b_instruction, 0);
    b_inst_address = 0;
    step();
    chk("b_err_clear", b_addr_err, 0);
    for (int i = 0; i < DEPTH_B; i++) begin
      b_address = AW'(i);
      step();
      chk("b_scan", b_data_out, mb[i]);
    end

    // Refill, then reset in the middle of a clear
    for (int i = 0; i < DEPTH_A; i++) begin
      address = AW'(i); data_in = DW'($urandom_range(255, 1)); write_en = 1'b1;
      step();
    end
    write_en = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (100) step();
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_inst", instruction, 0);
    chk("mid_rst_err", addr_err, 0);
    step();
    reset_n = 1'b1;
    count_busy(na, nb, err_seen);
    chk("restart_len", na, DEPTH_A);
    chk("restart_len_b", nb, DEPTH_B);
    for (int i = 0; i < DEPTH_A; i++) begin
      address = AW'(i); inst_address = AW'(DEPTH_A - 1 - i);
      step();
      chk("restart_scan", data_out, 0);
      chk("restart_scan_i", instruction, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
